rx_pam4_ber_checker: RTL and testbench
======================================

Name: rx_pam4_ber_checker

Overview:
- Downstream stage of the parallel DFE.
- Consumes the DFE's decided PAM4 levels (±SYMBOL_SEPERATION/2, ±3·SYMBOL_SEPERATION/2) and demaps them to 2-bit symbols.
- Self-synchronises a local PRBS7 reference to the received stream, then counts compared bits and bit errors for BER measurement of the noise/ISI simulation.
- Detects loss of lock over a sliding error window.

Parameters:
- SIGNAL_RESOLUTION, 8, width of the signed input level.
- SYMBOL_SEPERATION, 56, PAM4 level spacing; nominal levels are -84, -28, +28, +84.
- SEED_SYMS, 4, consecutive symbols shifted into the LFSR before tracking; must be ≥4.
- WIN_SYMS, 64, symbols per lock-monitor window.
- LOSS_THRESH, 16, window bit errors strictly above this drop lock.
- CNT_W, 32, width of the bit and error counters.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- sym_in  in  SIGNAL_RESOLUTION  signed decided level from the DFE
- sym_in_tgl  in  1  toggle-encoded valid: each level change marks one new symbol
- clr_counts  in  1  synchronous clear of the counters and lock_lost
- bits_out  out  2  demapped symbol, bit[1] is first in time
- bits_out_valid  out  1  one-cycle pulse per symbol
- locked  out  1  high while in TRACK
- lock_lost  out  1  sticky; set on a TRACK→HUNT drop
- bit_count  out  CNT_W  bits compared in TRACK, saturating
- err_count  out  CNT_W  mismatched bits in TRACK, saturating

Behaviour:
- Clock, reset and mandated-stage interface: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values: all outputs 0; tgl_q 0; LFSR 0; state HUNT; window counters 0.
- Symbol detect:
  - Event in cycle N when sym_in_tgl != tgl_q; tgl_q <= sym_in_tgl every cycle.
  - sym_in is sampled in cycle N.
  - bits_out, bits_out_valid, counters and state are updated at N+1 (latency 1).
  - No event means nothing advances.
- Slicing on the signed input:
  - ≥SEP → +84
  - 0..SEP-1 → +28
  - -SEP..-1 → -28
  - else → -84
  - Off-grid values are therefore sliced, not flagged.
- Mapping (natural binary): -84→00, -28→01, +28→10, +84→11.
- PRBS7, x^7+x^6+1:
  - State s[6:0]; nb = s[6]^s[5]; s <= {s[5:0], nb}.
  - Two steps per symbol, bit[1] first.
- HUNT:
  - Each symbol shifts the received bits into s instead of nb; seed_cnt increments.
  - When seed_cnt reaches SEED_SYMS: if s != 0, go to TRACK; else restart seeding with seed_cnt=0 (lock-up guard).
  - Counters hold in HUNT.
- TRACK:
  - s advances autonomously; predicted 2 bits are XORed with received.
  - bit_count += 2; err_count += popcount(mismatch); both saturate at all-ones with no wrap.
  - win_err accumulates the mismatches. At each WIN_SYMS-th symbol, evaluate win_err including the current symbol:
    - If > LOSS_THRESH: go to HUNT, clear seed_cnt, set lock_lost.
    - Otherwise clear win_err and the window counter.
- clr_counts:
  - Zeroes bit_count, err_count and lock_lost at the next edge.
  - On the same cycle as a symbol event, the clear wins and that symbol is not counted.
  - State and LFSR are unaffected.
- Reset mid-operation returns to HUNT immediately, counters 0.
- If both toggle edges arrive faster than once per cycle, the excess is lost; the upstream guarantees ≤1 event per cycle.

Optional Feature:
- Macro RX_BER_GRAY_MAP_EN.
- Defined: Gray demapping, -84→00, -28→01, +28→11, +84→10; PRBS comparison is on the Gray bits.
- Undefined: natural binary mapping as above.

Decomposition:
- Package rx_ber_pkg holds:
  - state enum {HUNT, TRACK}
  - PRBS7 tap constants
  - 2-bit level-code constants
  - popcount2 function
- Sub-module pam4_slicer_demap (combinational slice plus mapping, macro-aware) is instantiated once.
- LFSR, window logic and counters stay in the top module.

Test Plan:
- Clean PRBS7 stream, 1000 symbols, natural mapping → locked=1 after symbol 4; bit_count=1992, err_count=0, lock_lost=0.
- After lock, one +28 replaced by -28 → err_count=2 (natural) or 1 (RX_BER_GRAY_MAP_EN); locked stays 1.
- Random data in TRACK with WIN_SYMS=64, LOSS_THRESH=16 → at the first window end, locked=0, lock_lost=1; a clean stream then relocks after 4 symbols.
- Constant -84 symbols from reset → LFSR stays 0, locked never asserts, bit_count=0.
- sym_in_tgl held static for 100 cycles while sym_in changes → no bits_out_valid, counters unchanged; clr_counts coincident with a symbol → counts 0 and that symbol uncounted.
- Assert rstn low mid-TRACK with err_count=5 → all outputs 0 asynchronously; HUNT on release.
- Counter preload near all-ones (CNT_W=4 build): bit_count saturates at 15, no wrap.

Source files
------------

// File: rtl/rx_ber_pkg.sv
// Shared types and constants for the PAM4 BER checker: FSM states, PRBS7 taps,
// PAM4 level codes and a 2-bit popcount helper.
package rx_ber_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } ber_state_e;

  // x^7 + x^6 + 1 : feedback is s[6] ^ s[5]
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  localparam logic [1:0] CODE_N84      = 2'b00;
  localparam logic [1:0] CODE_N28      = 2'b01;
  localparam logic [1:0] CODE_P28_BIN  = 2'b10;
  localparam logic [1:0] CODE_P84_BIN  = 2'b11;
  localparam logic [1:0] CODE_P28_GRAY = 2'b11;
  localparam logic [1:0] CODE_P84_GRAY = 2'b10;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/pam4_slicer_demap.sv
// Slices a signed DFE decision onto the four PAM4 levels and demaps it to 2 bits.
// Define RX_BER_GRAY_MAP_EN for Gray demapping; natural binary otherwise.
module pam4_slicer_demap
  import rx_ber_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56
) (
  input  logic signed [SIGNAL_RESOLUTION-1:0] sym_i,
  output logic        [1:0]                   code_o
);

  localparam logic signed [SIGNAL_RESOLUTION-1:0] SEP_P = SIGNAL_RESOLUTION'(SYMBOL_SEPERATION);
  localparam logic signed [SIGNAL_RESOLUTION-1:0] SEP_N = SIGNAL_RESOLUTION'(-SYMBOL_SEPERATION);
  localparam logic signed [SIGNAL_RESOLUTION-1:0] ZERO  = '0;

`ifdef RX_BER_GRAY_MAP_EN
  localparam logic [1:0] CODE_P28 = CODE_P28_GRAY;
  localparam logic [1:0] CODE_P84 = CODE_P84_GRAY;
`else
  localparam logic [1:0] CODE_P28 = CODE_P28_BIN;
  localparam logic [1:0] CODE_P84 = CODE_P84_BIN;
`endif

  // Decision boundaries sit at -SEP, 0, +SEP; off-grid inputs are simply sliced.
  always_comb begin
    code_o = CODE_N84;
    if (sym_i >= SEP_P) begin
      code_o = CODE_P84;
    end else if (sym_i >= ZERO) begin
      code_o = CODE_P28;
    end else if (sym_i >= SEP_N) begin
      code_o = CODE_N28;
    end
  end

endmodule

// File: rtl/rx_pam4_ber_checker.sv
// PAM4 BER checker: self-synchronising PRBS7 reference, saturating bit/error
// counters and windowed loss-of-lock detection. Honours RX_BER_GRAY_MAP_EN.
module rx_pam4_ber_checker
  import rx_ber_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int SEED_SYMS         = 4,
  parameter int WIN_SYMS          = 64,
  parameter int LOSS_THRESH       = 16,
  parameter int CNT_W             = 32
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic signed [SIGNAL_RESOLUTION-1:0] sym_in,
  input  logic                                sym_in_tgl,
  input  logic                                clr_counts,
  output logic        [1:0]                   bits_out,
  output logic                                bits_out_valid,
  output logic                                locked,
  output logic                                lock_lost,
  output logic        [CNT_W-1:0]             bit_count,
  output logic        [CNT_W-1:0]             err_count
);

  localparam int SEED_W = $clog2(SEED_SYMS + 1);
  localparam int WIN_W  = $clog2(WIN_SYMS + 1);
  localparam int WERR_W = $clog2(2 * WIN_SYMS + LOSS_THRESH + 2);

  ber_state_e        state_q;
  logic              tgl_q;
  logic [6:0]        lfsr_q;
  logic [SEED_W-1:0] seed_cnt_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [WERR_W-1:0] win_err_q;
  logic [1:0]        bits_out_q;
  logic              bits_valid_q;
  logic              lock_lost_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0]  err_cnt_q;

  logic              sym_evt;
  logic [1:0]        code;
  logic [6:0]        lfsr_seed_d;
  logic [6:0]        lfsr_s1;
  logic [6:0]        lfsr_trk_d;
  logic [1:0]        n_mis;
  logic [CNT_W:0]    bit_sum;
  logic [CNT_W:0]    err_sum;
  logic [CNT_W-1:0]  bit_cnt_d;
  logic [CNT_W-1:0]  err_cnt_d;
  logic [WERR_W-1:0] win_err_d;
  logic              win_end;
  logic              seed_done;

  pam4_slicer_demap #(
    .SIGNAL_RESOLUTION(SIGNAL_RESOLUTION),
    .SYMBOL_SEPERATION(SYMBOL_SEPERATION)
  ) u_slicer (
    .sym_i (sym_in),
    .code_o(code)
  );

  assign sym_evt     = sym_in_tgl ^ tgl_q;
  assign lfsr_seed_d = {lfsr_q[4:0], code};

  // Two PRBS steps per symbol; the first step's output bit is bit[1].
  assign lfsr_s1     = prbs7_step(lfsr_q);
  assign lfsr_trk_d  = prbs7_step(lfsr_s1);
  assign n_mis       = popcount2({lfsr_s1[0], lfsr_trk_d[0]} ^ code);

  assign bit_sum     = {1'b0, bit_cnt_q} + (CNT_W+1)'(2);
  assign err_sum     = {1'b0, err_cnt_q} + (CNT_W+1)'(n_mis);
  assign bit_cnt_d   = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
  assign err_cnt_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  assign win_err_d   = win_err_q + WERR_W'(n_mis);
  assign win_end     = (win_cnt_q == WIN_W'(WIN_SYMS - 1));
  assign seed_done   = (seed_cnt_q == SEED_W'(SEED_SYMS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= HUNT;
      tgl_q        <= 1'b0;
      lfsr_q       <= '0;
      seed_cnt_q   <= '0;
      win_cnt_q    <= '0;
      win_err_q    <= '0;
      bits_out_q   <= '0;
      bits_valid_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      bit_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      tgl_q        <= sym_in_tgl;
      bits_valid_q <= sym_evt;
      if (sym_evt) begin
        bits_out_q <= code;
        case (state_q)
          HUNT: begin
            lfsr_q <= lfsr_seed_d;
            if (seed_done) begin
              seed_cnt_q <= '0;
              // An all-zero seed would lock the LFSR up; keep seeding instead.
              if (lfsr_seed_d != '0) begin
                state_q   <= TRACK;
                win_cnt_q <= '0;
                win_err_q <= '0;
              end
            end else begin
              seed_cnt_q <= seed_cnt_q + 1'b1;
            end
          end
          TRACK: begin
            lfsr_q    <= lfsr_trk_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            if (win_end) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
              if (win_err_d > WERR_W'(LOSS_THRESH)) begin
                state_q     <= HUNT;
                seed_cnt_q  <= '0;
                lock_lost_q <= 1'b1;
              end
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              win_err_q <= win_err_d;
            end
          end
        endcase
      end
      // Placed last so a clear overrides any same-cycle count or lock_lost update.
      if (clr_counts) begin
        bit_cnt_q   <= '0;
        err_cnt_q   <= '0;
        lock_lost_q <= 1'b0;
      end
    end
  end

  assign bits_out       = bits_out_q;
  assign bits_out_valid = bits_valid_q;
  assign locked         = (state_q == TRACK);
  assign lock_lost      = lock_lost_q;
  assign bit_count      = bit_cnt_q;
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_rx_pam4_ber_checker.sv
// Self-checking bench for rx_pam4_ber_checker: randomized PAM4 stimulus against a
// bit-history reference model, with a second CNT_W=4 instance for saturation.
module tb_rx_pam4_ber_checker;

  localparam int SEP  = 56;
  localparam int SEED = 4;
  localparam int WIN  = 64;
  localparam int THR  = 16;
`ifdef RX_BER_GRAY_MAP_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic signed [7:0] sym_in;
  logic              sym_in_tgl;
  logic              clr_counts;
  logic [1:0]        bits_out, bits_out4;
  logic              bits_out_valid, bits_out_valid4;
  logic              locked, locked4, lock_lost, lock_lost4;
  logic [31:0]       bit_count, err_count;
  logic [3:0]        bit_count4, err_count4;

  rx_pam4_ber_checker u_dut (
    .clk(clk), .rstn(rstn), .sym_in(sym_in), .sym_in_tgl(sym_in_tgl),
    .clr_counts(clr_counts), .bits_out(bits_out), .bits_out_valid(bits_out_valid),
    .locked(locked), .lock_lost(lock_lost), .bit_count(bit_count), .err_count(err_count)
  );

  rx_pam4_ber_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .sym_in(sym_in), .sym_in_tgl(sym_in_tgl),
    .clr_counts(clr_counts), .bits_out(bits_out4), .bits_out_valid(bits_out_valid4),
    .locked(locked4), .lock_lost(lock_lost4), .bit_count(bit_count4), .err_count(err_count4)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int         n_vec, n_bad;
  logic [1:0] exp_q[$];
  bit         m_hist[$];
  bit         tx_hist[$];
  bit         m_locked, m_lost, m_valid, inj_pending;
  int         m_seed, m_win_cnt, m_win_err, m_bits, m_errs, m_bits4, m_errs4;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_locked = 0; m_lost = 0; m_valid = 0;
    m_seed = 0; m_win_cnt = 0; m_win_err = 0;
    m_bits = 0; m_errs = 0; m_bits4 = 0; m_errs4 = 0;
    m_hist = '{0, 0, 0, 0, 0, 0, 0};
    exp_q.delete();
  endfunction

  function automatic int level_idx(input int v);
    if (v >= SEP) return 3;
    if (v >= 0)   return 2;
    if (v >= -SEP) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] code_of_idx(input int idx);
    logic [1:0] i;
    i = idx[1:0];
    return GRAY ? (i ^ (i >> 1)) : i;
  endfunction

  function automatic int idx_of_code(input logic [1:0] c);
    logic [1:0] i;
    i = GRAY ? {c[1], c[1] ^ c[0]} : c;
    return int'(i);
  endfunction

  // Random value inside a level's slice region, biased toward its edges.
  function automatic int rand_level(input int idx);
    int lo, hi, r;
    case (idx)
      3:       begin lo = SEP;  hi = 127;      end
      2:       begin lo = 0;    hi = SEP - 1;  end
      1:       begin lo = -SEP; hi = -1;       end
      default: begin lo = -128; hi = -SEP - 1; end
    endcase
    r = int'($urandom_range(0, 3));
    if (r == 0) return lo;
    if (r == 1) return hi;
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  function automatic bit tx_next();
    bit b;
    b = tx_hist[0] ^ tx_hist[1];
    tx_hist.push_back(b);
    void'(tx_hist.pop_front());
    return b;
  endfunction

  // Reference: history of the last 7 reference bits, oldest first.
  function automatic void model_step(input logic [1:0] c, input bit clr);
    bit p, any;
    int mis;
    if (!m_locked) begin
      m_hist.push_back(c[1]); void'(m_hist.pop_front());
      m_hist.push_back(c[0]); void'(m_hist.pop_front());
      m_seed++;
      if (m_seed == SEED) begin
        m_seed = 0;
        any = 0;
        foreach (m_hist[i]) any |= m_hist[i];
        if (any) begin
          m_locked = 1; m_win_cnt = 0; m_win_err = 0;
        end
      end
    end else begin
      mis = 0;
      for (int k = 1; k >= 0; k--) begin
        p = m_hist[0] ^ m_hist[1];
        m_hist.push_back(p); void'(m_hist.pop_front());
        if (p != c[k]) mis++;
      end
      m_bits += 2;
      m_errs += mis;
      m_bits4 = (m_bits4 + 2 > 15) ? 15 : m_bits4 + 2;
      m_errs4 = (m_errs4 + mis > 15) ? 15 : m_errs4 + mis;
      m_win_err += mis;
      m_win_cnt++;
      if (m_win_cnt == WIN) begin
        if (m_win_err > THR) begin
          m_locked = 0; m_seed = 0; m_lost = 1;
        end
        m_win_cnt = 0; m_win_err = 0;
      end
    end
    if (clr) begin
      m_bits = 0; m_errs = 0; m_bits4 = 0; m_errs4 = 0; m_lost = 0;
    end
  endfunction

  task automatic check_outputs();
    logic [1:0] expv;
    check_val("valid", bits_out_valid, m_valid);
    check_val("valid4", bits_out_valid4, m_valid);
    if (m_valid && exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      check_val("bits_out", bits_out, expv);
      check_val("bits_out4", bits_out4, expv);
    end
    check_val("locked", locked, m_locked);
    check_val("locked4", locked4, m_locked);
    check_val("lock_lost", lock_lost, m_lost);
    check_val("lock_lost4", lock_lost4, m_lost);
    check_val("bit_count", bit_count, m_bits);
    check_val("err_count", err_count, m_errs);
    check_val("bit_count4", bit_count4, m_bits4);
    check_val("err_count4", err_count4, m_errs4);
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_sym(input int lvl, input bit clr);
    logic [1:0] c;
    sym_in     = 8'(lvl);
    sym_in_tgl = ~sym_in_tgl;
    clr_counts = clr;
    c = code_of_idx(level_idx(lvl));
    model_step(c, clr);
    m_valid = 1;
    exp_q.push_back(c);
    @(negedge clk);
    clr_counts = 1'b0;
    check_outputs();
  endtask

  task automatic idle_cycle();
    sym_in     = 8'($urandom_range(0, 255));
    clr_counts = 1'b0;
    m_valid    = 0;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_prbs(input int n, input bit clr_first);
    bit b1, b0;
    int idx, lvl;
    for (int k = 0; k < n; k++) begin
      b1  = tx_next();
      b0  = tx_next();
      idx = idx_of_code({b1, b0});
      lvl = rand_level(idx);
      if (inj_pending && idx == 2) begin
        lvl = -28;
        inj_pending = 0;
      end
      drive_sym(lvl, clr_first && (k == 0));
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end
  endtask

  task automatic do_reset();
    #2;
    rstn       = 1'b0;
    sym_in_tgl = 1'b0;
    clr_counts = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_bits_out", bits_out, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0; n_bad = 0; inj_pending = 0;
    rstn = 1'b0; sym_in = '0; sym_in_tgl = 1'b0; clr_counts = 1'b0;
    model_reset();
    tx_hist = '{1, 0, 0, 1, 0, 1, 1};
    repeat (3) @(negedge clk);
    check_outputs();
    check_val("rst_bits_out", bits_out, 0);
    rstn = 1'b1;
    @(negedge clk);

    // constant -84 symbols: seed stays zero, never locks
    for (int k = 0; k < 20; k++) drive_sym(rand_level(0), 1'b0);
    check_val("const_locked", locked, 0);
    check_val("const_bits", bit_count, 0);

    // clean PRBS7 stream from reset
    do_reset();
    send_prbs(1000, 1'b0);
    check_val("clean_bits", bit_count, 1992);
    check_val("clean_errs", err_count, 0);
    check_val("clean_lost", lock_lost, 0);
    check_val("clean_locked", locked, 1);
    check_val("sat_bits4", bit_count4, 15);

    // single +28 -> -28 decision error
    inj_pending = 1;
    send_prbs(60, 1'b0);
    check_val("inj_errs", err_count, GRAY ? 1 : 2);
    check_val("inj_locked", locked, 1);

    // toggle static while the level wanders
    repeat (100) idle_cycle();

    // clear coincident with a symbol
    send_prbs(1, 1'b1);
    check_val("clr_bits", bit_count, 0);
    check_val("clr_errs", err_count, 0);

    // random data until a loss of lock, then a clean stream relocks
    for (int k = 0; k < 500 && !m_lost; k++)
      drive_sym(rand_level(int'($urandom_range(0, 3))), 1'b0);
    check_val("rand_lost", lock_lost, 1);
    send_prbs(300, 1'b0);
    check_val("relock", locked, 1);

    // reset mid-TRACK with errors on the counters
    inj_pending = 1;
    send_prbs(30, 1'b0);
    do_reset();
    send_prbs(20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
